// File: rtl/boid_vga_pkg.sv
// Shared definitions for the boid VGA raster path: default resolution,
// coordinate format, framebuffer address width, pixel colour and FSM states.
package boid_vga_pkg;

  localparam int DEF_H_RES     = 640;
  localparam int DEF_V_RES     = 480;
  localparam int DEF_FRAC_BITS = 16;
  localparam int ADDR_W        = 19;

  typedef logic [7:0] color_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UPDATE = 3'd1,
    ST_SCAN   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/chk_delay_line.sv
// Fixed-depth shift register that carries a probe's valid bit and address
// alongside the accelerator latency; reset clears every stage.
module chk_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/boid_raster_writer.sv
// Per-frame sequencer: runs the boid update for a fixed burst, then probes every
// pixel in raster order and writes the accelerator's hit/miss into the framebuffer.
//
// state  | meaning
// IDLE   | waiting for start
// UPDATE | upd_en high for UPD_CYCLES cycles
// SCAN   | one probe per cycle over the whole frame
// DRAIN  | last CHK_LAT probes retiring into the framebuffer
// DONE   | one-cycle frame_done pulse
module boid_raster_writer
  import boid_vga_pkg::*;
#(
  parameter int     H_RES      = DEF_H_RES,
  parameter int     V_RES      = DEF_V_RES,
  parameter int     CHK_LAT    = 2,
  parameter int     UPD_CYCLES = 64,
  parameter int     FRAC_BITS  = DEF_FRAC_BITS,
  parameter color_t BOID_COLOR = 8'hFF,
  parameter color_t BG_COLOR   = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              upd_en,
  output logic [31:0]       x_chk,
  output logic [31:0]       y_chk,
  input  logic              is_boid_here,
  output logic [ADDR_W-1:0] wr_addr,
  output color_t            wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              frame_done
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int TW = 16;

  state_e            state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              probe_vld;

  logic [ADDR_W:0]   dly_in, dly_out;
  logic              dly_vld;
  logic [ADDR_W-1:0] dly_addr;
  logic [ADDR_W-1:0] last_addr_q;
  color_t            last_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    x_d        = x_q;
    y_d        = y_q;
    addr_d     = addr_q;
    probe_vld  = 1'b0;
    upd_en     = 1'b0;
    frame_done = 1'b0;
    busy       = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_UPDATE;
          tmr_d   = TW'(UPD_CYCLES - 1);
        end
      end
      ST_UPDATE: begin
        upd_en = 1'b1;
        if (tmr_q == '0) state_d = ST_SCAN;
        else             tmr_d   = tmr_q - 1'b1;
      end
      ST_SCAN: begin
        probe_vld = 1'b1;
        addr_d    = addr_q + 1'b1;
        if (x_q == XW'(H_RES - 1)) begin
          x_d = '0;
          if (y_q == YW'(V_RES - 1)) begin
            // counters rewind here so the probe outputs rest at pixel (0,0)
            y_d     = '0;
            addr_d  = '0;
            state_d = ST_DRAIN;
            tmr_d   = TW'(CHK_LAT - 1);
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (tmr_q == '0) state_d = ST_DONE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign x_chk = 32'(x_q) << FRAC_BITS;
  assign y_chk = 32'(y_q) << FRAC_BITS;

  assign dly_in = {probe_vld, addr_q};

  chk_delay_line #(
    .DEPTH (CHK_LAT),
    .WIDTH (ADDR_W + 1)
  ) u_chk_delay_line (
    .clk   (clk),
    .reset (reset),
    .d_i   (dly_in),
    .q_o   (dly_out)
  );

  assign dly_vld  = dly_out[ADDR_W];
  assign dly_addr = dly_out[ADDR_W-1:0];

  // Write port is combinational off the delay line so an async reset kills wr_en at once.
  assign wr_en   = dly_vld;
  assign wr_addr = dly_vld ? dly_addr : last_addr_q;
  assign wr_data = dly_vld ? (is_boid_here ? BOID_COLOR : BG_COLOR) : last_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_addr_q <= '0;
      last_data_q <= '0;
    end else if (dly_vld) begin
      last_addr_q <= wr_addr;
      last_data_q <= wr_data;
    end
  end

endmodule

// File: tb/tb_boid_raster_writer.sv
// Directed bench for boid_raster_writer on a 4x3 frame; a second instance with
// CHK_LAT=1 shares clock, reset and start.
module tb_boid_raster_writer;
  import boid_vga_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;

  logic              upd_en_a, wr_en_a, busy_a, done_a, hit_a;
  logic [31:0]       x_a, y_a;
  logic [ADDR_W-1:0] wr_addr_a;
  color_t            wr_data_a;

  logic              upd_en_b, wr_en_b, busy_b, done_b, hit_b;
  logic [31:0]       x_b, y_b;
  logic [ADDR_W-1:0] wr_addr_b;
  color_t            wr_data_b;

  logic [1:0] pipe_a = 2'b00;
  logic       pipe_b = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Accelerator model: hit only at pixel (2,1), answered CHK_LAT cycles later.
  always @(posedge clk) begin
    pipe_a <= {pipe_a[0], (x_a == 32'h0002_0000 && y_a == 32'h0001_0000)};
    pipe_b <= (x_b == 32'h0002_0000 && y_b == 32'h0001_0000);
  end
  assign hit_a = pipe_a[1];
  assign hit_b = pipe_b;

  boid_raster_writer #(
    .H_RES(4), .V_RES(3), .CHK_LAT(2), .UPD_CYCLES(3), .FRAC_BITS(16),
    .BOID_COLOR(8'hFF), .BG_COLOR(8'h00)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .upd_en(upd_en_a),
    .x_chk(x_a), .y_chk(y_a), .is_boid_here(hit_a),
    .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_en(wr_en_a),
    .busy(busy_a), .frame_done(done_a)
  );

  boid_raster_writer #(
    .H_RES(4), .V_RES(3), .CHK_LAT(1), .UPD_CYCLES(3), .FRAC_BITS(16),
    .BOID_COLOR(8'hFF), .BG_COLOR(8'h00)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start), .upd_en(upd_en_b),
    .x_chk(x_b), .y_chk(y_b), .is_boid_here(hit_b),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_en(wr_en_b),
    .busy(busy_b), .frame_done(done_b)
  );

  // Raises start for cycle 0; the caller's loop then counts cycles 1, 2, ...
  task automatic start_pulse();
    @(posedge clk); #1;
    start = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (upd_en_a !== 1'b0) begin bad++; $display("FAIL reset_upd_en got=%b exp=0", upd_en_a); end
    total++; if (wr_en_a !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", wr_en_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", done_a); end
    total++; if (x_a !== 32'h0 || y_a !== 32'h0) begin bad++; $display("FAIL reset_chk got=%h,%h exp=0,0", x_a, y_a); end
    total++; if (wr_addr_a !== 19'h0 || wr_data_a !== 8'h00) begin bad++; $display("FAIL reset_wr got=%h,%h exp=0,0", wr_addr_a, wr_data_a); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_frame();
    int nwr;
    nwr = 0;
    start_pulse();
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      total++;
      if (upd_en_a !== 1'((c >= 1) && (c <= 3))) begin bad++; $display("FAIL frame_upd_en c=%0d got=%b", c, upd_en_a); end
      total++;
      if (wr_en_a !== 1'((c >= 6) && (c <= 17))) begin bad++; $display("FAIL frame_wr_en c=%0d got=%b", c, wr_en_a); end
      if (wr_en_a === 1'b1) begin
        nwr++;
        total++;
        if (wr_addr_a !== 19'(c - 6)) begin bad++; $display("FAIL frame_addr c=%0d got=%0d exp=%0d", c, wr_addr_a, c - 6); end
        total++;
        if (wr_data_a !== ((c - 6 == 6) ? 8'hFF : 8'h00)) begin bad++; $display("FAIL frame_data c=%0d got=%h", c, wr_data_a); end
      end
      total++;
      if (done_a !== 1'(c == 18)) begin bad++; $display("FAIL frame_done c=%0d got=%b", c, done_a); end
      total++;
      if (busy_a !== 1'(c <= 18)) begin bad++; $display("FAIL frame_busy c=%0d got=%b", c, busy_a); end
      if (c >= 18) begin
        total++;
        if (wr_addr_a !== 19'd11 || wr_data_a !== 8'h00) begin bad++; $display("FAIL frame_hold c=%0d got=%0d,%h exp=11,00", c, wr_addr_a, wr_data_a); end
      end
    end
    total++;
    if (nwr != 12) begin bad++; $display("FAIL frame_write_count got=%0d exp=12", nwr); end
  endtask

  task automatic test_probe();
    start_pulse();
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (c == 4) begin
        total++;
        if (x_a !== 32'h0 || y_a !== 32'h0) begin bad++; $display("FAIL probe_0_0 got=%h,%h", x_a, y_a); end
      end
      if (c == 10) begin
        total++;
        if (x_a !== 32'h0002_0000 || y_a !== 32'h0001_0000) begin bad++; $display("FAIL probe_2_1 got=%h,%h", x_a, y_a); end
      end
      if (c == 12) begin
        total++;
        if (x_a !== 32'h0 || y_a !== 32'h0002_0000) begin bad++; $display("FAIL probe_0_2 got=%h,%h", x_a, y_a); end
      end
      if (c == 15) begin
        total++;
        if (x_a !== 32'h0003_0000 || y_a !== 32'h0002_0000) begin bad++; $display("FAIL probe_3_2 got=%h,%h exp=00030000,00020000", x_a, y_a); end
      end
    end
  endtask

  task automatic test_start_held();
    int upd_cnt, done_cnt;
    upd_cnt = 0;
    done_cnt = 0;
    start_pulse();
    // start stays high through the whole frame and drops before the first IDLE cycle
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 19) start = 1'b0;
      if (upd_en_a === 1'b1) upd_cnt++;
      if (done_a === 1'b1) done_cnt++;
      total++;
      if (busy_a !== 1'(c <= 18)) begin bad++; $display("FAIL held_busy c=%0d got=%b", c, busy_a); end
    end
    total++; if (upd_cnt != 3) begin bad++; $display("FAIL held_upd_cycles got=%0d exp=3", upd_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL held_frames got=%0d exp=1", done_cnt); end
    start_pulse();
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (upd_en_a !== 1'b1) begin bad++; $display("FAIL held_restart got=%b exp=1", upd_en_a); end
    repeat (20) @(posedge clk);
  endtask

  task automatic test_reset_mid_scan();
    int nwr;
    nwr = 0;
    start_pulse();
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
    end
    total++;
    if (wr_en_a !== 1'b1 || wr_addr_a !== 19'd5) begin bad++; $display("FAIL abort_pre got=%b,%0d exp=1,5", wr_en_a, wr_addr_a); end
    reset = 1'b0;
    #1;
    total++; if (wr_en_a !== 1'b0) begin bad++; $display("FAIL abort_wr_en got=%b exp=0", wr_en_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy_a); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (wr_en_a === 1'b1) nwr++;
      total++;
      if (busy_a !== 1'b0) begin bad++; $display("FAIL abort_idle_busy c=%0d got=%b", c, busy_a); end
    end
    total++; if (nwr != 0) begin bad++; $display("FAIL abort_writes got=%0d exp=0", nwr); end
    test_frame();
  endtask

  task automatic test_lat1();
    int nwr;
    nwr = 0;
    start_pulse();
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      total++;
      if (wr_en_b !== 1'((c >= 5) && (c <= 16))) begin bad++; $display("FAIL lat1_wr_en c=%0d got=%b", c, wr_en_b); end
      if (wr_en_b === 1'b1) begin
        nwr++;
        total++;
        if (wr_addr_b !== 19'(c - 5)) begin bad++; $display("FAIL lat1_addr c=%0d got=%0d exp=%0d", c, wr_addr_b, c - 5); end
        total++;
        if (wr_data_b !== ((c - 5 == 6) ? 8'hFF : 8'h00)) begin bad++; $display("FAIL lat1_data c=%0d got=%h", c, wr_data_b); end
      end
      total++;
      if (done_b !== 1'(c == 17)) begin bad++; $display("FAIL lat1_done c=%0d got=%b", c, done_b); end
    end
    total++;
    if (nwr != 12) begin bad++; $display("FAIL lat1_write_count got=%0d exp=12", nwr); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_probe();
    test_start_held();
    test_reset_mid_scan();
    test_lat1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/boid_raster_writer.md
BOID_RASTER_WRITER -- requirements
Module: boid_raster_writer

Interface
REQ-001 SHALL have parameter H_RES, default 640, meaning pixels per line.
REQ-002 SHALL have parameter V_RES, default 480, meaning lines per frame.
REQ-003 SHALL have parameter CHK_LAT, default 2, meaning cycles from x_chk/y_chk to a valid is_boid_here; legal range 1..8.
REQ-004 SHALL have parameter UPD_CYCLES, default 64, meaning cycles upd_en is held high per frame.
REQ-005 SHALL have parameter FRAC_BITS, default 16, meaning fixed-point fraction bits of the coordinates.
REQ-006 SHALL have parameters BOID_COLOR, default 8'hFF, and BG_COLOR, default 8'h00.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-low (0 = reset asserted).
REQ-009 SHALL have port start, input, 1 bit: begin one frame (update then scan).
REQ-010 SHALL have port upd_en, output, 1 bit: drives the accelerator en.
REQ-011 SHALL have ports x_chk and y_chk, output, 32 bits each: probe coordinate equal to pixel index << FRAC_BITS, zero-filled.
REQ-012 SHALL have port is_boid_here, input, 1 bit: accelerator hit, valid CHK_LAT cycles after its probe.
REQ-013 SHALL have port wr_addr, output, 19 bits: M10k framebuffer address.
REQ-014 SHALL have port wr_data, output, 8 bits: pixel colour.
REQ-015 SHALL have port wr_en, output, 1 bit: framebuffer write strobe.
REQ-016 SHALL have port busy, output, 1 bit: high outside IDLE.
REQ-017 SHALL have port frame_done, output, 1 bit: one-cycle pulse on frame completion.

Function
REQ-018 SHALL implement FSM states IDLE, UPDATE, SCAN, DRAIN, DONE.
REQ-019 IDLE->UPDATE SHALL occur on start=1; start in any other state SHALL be ignored.
REQ-020 UPDATE: upd_en=1 for exactly UPD_CYCLES cycles, then ->SCAN; upd_en=0 in all other states.
REQ-021 SCAN: one probe per cycle, raster order x=0..H_RES-1 inner, y=0..V_RES-1 outer; on the probe (H_RES-1,V_RES-1) ->DRAIN.
REQ-022 Each probe SHALL carry a valid bit and address y*H_RES+x, maintained by an incrementing counter, through a CHK_LAT-deep delay line.
REQ-023 When the delayed valid is 1: wr_en=1, wr_addr=the delayed address, wr_data=BOID_COLOR if is_boid_here else BG_COLOR.
REQ-024 DRAIN SHALL last CHK_LAT cycles, until the last write retires, then ->DONE.
REQ-025 DONE SHALL last 1 cycle with frame_done=1, then ->IDLE.
REQ-026 Exactly H_RES*V_RES writes per frame, each address written once, with no gaps during SCAN after the first CHK_LAT cycles.
REQ-027 When wr_en=0, wr_addr and wr_data SHALL hold their last values.
REQ-028 Total frame latency from start to frame_done SHALL be 1+UPD_CYCLES+H_RES*V_RES+CHK_LAT cycles.

Reset
REQ-029 While reset=0: state=IDLE; upd_en, wr_en, busy, frame_done=0; x_chk, y_chk, wr_addr, wr_data=0; delay line valid bits cleared.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately with no further writes; after reset deasserts, the block SHALL wait for a new start.

Structure
REQ-031 A shared package boid_vga_pkg SHALL hold the default resolution, FRAC_BITS, the address width (19), the colour typedef (8-bit), and the FSM state enum.
REQ-032 The probe delay SHALL be a sub-module chk_delay_line (parameterised depth and width, carrying valid+address, reset-clearable).

Verification
REQ-033 The bench SHALL use H_RES=4, V_RES=3, CHK_LAT=2, UPD_CYCLES=3, with an accelerator model returning 1 only for pixel (2,1).
REQ-034 Scenario: start pulse -> upd_en high cycles 1-3; 12 writes at addr 0..11 in order; addr 6 carries 8'hFF, all others 8'h00; frame_done exactly at cycle 18.
REQ-035 Scenario: probe at pixel (3,2) -> x_chk=32'h0003_0000, y_chk=32'h0002_0000.
REQ-036 Scenario: start held high for 20 cycles -> only one frame; busy stays high until DONE; no second upd_en burst until start is re-asserted in IDLE.
REQ-037 Scenario: reset=0 asserted during SCAN at addr 5 -> wr_en=0 the same cycle; no writes follow; busy=0; a new start yields a full 12-write frame.
REQ-038 Scenario: CHK_LAT=1 regeneration -> still 12 writes, frame_done at cycle 17.
